// File: rtl/aes_byte_loader.sv
// Assembles a 32-byte key+data stream into one 128-bit key and one 128-bit block for the AES core.
// Define AES_LOADER_KEY_HOLD_EN to keep the key so that later frames carry 16 data bytes only.
module aes_byte_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [127:0] blk_key,
  output logic [127:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [5:0]   byte_cnt,
  output logic         timeout_err
);

  // Count is 6 bits wide so that it can show 32 while the block is held.
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic        TOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    HOLD      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic               tout_q, tout_d;
  logic               accept;
  logic               idle_run;
  logic               tout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      cnt_q   <= '0;
      idle_q  <= '0;
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      key_q   <= key_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    key_d    = key_q;
    data_d   = data_q;
    tout_d   = 1'b0;
    accept   = in_valid && (state_q != HOLD) && !abort;
    idle_run = TOUT_EN && (state_q != HOLD) && (cnt_q != '0);
    // An accepted byte always beats a timeout landing on the same edge.
    tout_hit = idle_run && !accept && (idle_q == IDLE_LAST);

    if (abort || tout_hit) begin
      state_d = LOAD_KEY;
      cnt_d   = '0;
      idle_d  = '0;
      tout_d  = !abort;
    end else begin
      if (accept) begin
        cnt_d  = cnt_q + CNT_W'(1);
        idle_d = '0;
      end else if (idle_run) begin
        idle_d = idle_q + IDLE_W'(1);
      end

      case (state_q)
        LOAD_KEY: begin
          if (accept) begin
            key_d = {key_q[119:0], in_byte};
            if (cnt_q == CNT_W'(15)) state_d = LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (accept) begin
            data_d = {data_q[119:0], in_byte};
            if (cnt_q == CNT_W'(31)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (blk_ready) begin
            idle_d = '0;
`ifdef AES_LOADER_KEY_HOLD_EN
            state_d = LOAD_DATA;
            cnt_d   = CNT_W'(16);
`else
            state_d = LOAD_KEY;
            cnt_d   = '0;
`endif
          end
        end
        default: begin
          state_d = LOAD_KEY;
          cnt_d   = '0;
          idle_d  = '0;
        end
      endcase
    end

    valid_d = (state_d == HOLD);
  end

  // Held low through reset so no byte is taken before the loader is live.
  assign in_ready    = !rst && (state_q != HOLD);
  assign blk_key     = key_q;
  assign blk_data    = data_q;
  assign blk_valid   = valid_q;
  assign byte_cnt    = cnt_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: table-driven frames checked by a scoreboard, plus abort/timeout/reset corners.
module tb_aes_byte_loader;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_byte = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         abort = 1'b0;
  logic [127:0] blk_key;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [5:0]   byte_cnt;
  logic         timeout_err;

  aes_byte_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .blk_key(blk_key), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .byte_cnt(byte_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
  } blk_t;

`ifdef AES_LOADER_KEY_HOLD_EN
  localparam logic [127:0] REL_CNT = 128'd16;
`else
  localparam logic [127:0] REL_CNT = 128'd0;
`endif

  int   checks = 0;
  int   errors = 0;
  blk_t sb_q[$];
  blk_t vecs[4];
  logic vld_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rising blk_valid must match the oldest pushed block.
  always @(negedge clk) begin
    blk_t e;
    if (!rst && blk_valid && !vld_prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: blk_valid rose with key %0h but no block expected", blk_key);
      end else begin
        e = sb_q.pop_front();
        if (blk_key !== e.key || blk_data !== e.data) begin
          errors++;
          $display("FAIL sb_block: got key %0h data %0h expected key %0h data %0h",
                   blk_key, blk_data, e.key, e.data);
        end
      end
    end
    vld_prev = blk_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_byte  = v[127-8*i -: 8];
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] k, input logic [127:0] d);
    send_bytes(k, 16);
    send_bytes(d, 15);
    chk("valid_before_last", 128'(blk_valid), 128'd0);
    in_valid = 1'b1;
    in_byte  = d[7:0];
    cyc();
    in_valid = 1'b0;
    chk("valid_latency", 128'(blk_valid), 128'd1);
    chk("cnt_at_hold", 128'(byte_cnt), 128'd32);
  endtask

  task automatic release_blk();
    blk_ready = 1'b1;
    cyc();
    blk_ready = 1'b0;
    chk("rel_valid", 128'(blk_valid), 128'd0);
    chk("rel_cnt", 128'(byte_cnt), REL_CNT);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_cnt", 128'(byte_cnt), 128'd0);
  endtask

  initial begin
    blk_t b;
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, data: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: '1, data: '0};
    vecs[2] = '{key: {$urandom, $urandom, $urandom, $urandom}, data: {$urandom, $urandom, $urandom, $urandom}};
    vecs[3] = '{key: 128'h8000_0000_0000_0000_0000_0000_0000_0001, data: 128'h0123456789abcdeffedcba9876543210};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_cnt", 128'(byte_cnt), 128'd0);
    chk("rst_valid", 128'(blk_valid), 128'd0);
    chk("rst_tout", 128'(timeout_err), 128'd0);
    chk("rst_key", blk_key, 128'd0);
    chk("rst_data", blk_data, 128'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);
    cyc();

    // Table of full frames
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(vecs[i]);
      send_frame(vecs[i].key, vecs[i].data);
      release_blk();
      pulse_abort();
    end

    // HOLD with extra bytes offered and blk_ready low
    sb_q.push_back(vecs[0]);
    send_frame(vecs[0].key, vecs[0].data);
    in_valid = 1'b1;
    in_byte  = 8'ha5;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_in_ready", 128'(in_ready), 128'd0);
      chk("hold_cnt", 128'(byte_cnt), 128'd32);
      chk("hold_key", blk_key, vecs[0].key);
      chk("hold_data", blk_data, vecs[0].data);
      chk("hold_valid", 128'(blk_valid), 128'd1);
    end
    in_valid = 1'b0;
    release_blk();
    chk("after_rel_in_ready", 128'(in_ready), 128'd1);

`ifdef AES_LOADER_KEY_HOLD_EN
    // Data-only frame reuses the held key
    b = '{key: vecs[0].key, data: vecs[3].data};
    sb_q.push_back(b);
    send_bytes(vecs[3].data, 16);
    chk("kh_valid", 128'(blk_valid), 128'd1);
    chk("kh_key", blk_key, vecs[0].key);
    chk("kh_data", blk_data, vecs[3].data);
    release_blk();
`endif
    pulse_abort();

    // Abort after 20 bytes; byte offered with abort is dropped
    send_bytes(vecs[2].key, 16);
    send_bytes(vecs[2].data, 4);
    chk("pre_abort_cnt", 128'(byte_cnt), 128'd20);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hff;
    cyc();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort20_cnt", 128'(byte_cnt), 128'd0);
    chk("abort20_valid", 128'(blk_valid), 128'd0);
    sb_q.push_back(vecs[3]);
    send_frame(vecs[3].key, vecs[3].data);

    // Abort in HOLD beats blk_ready; registers keep their contents
    abort     = 1'b1;
    blk_ready = 1'b1;
    cyc();
    abort     = 1'b0;
    blk_ready = 1'b0;
    chk("hold_abort_valid", 128'(blk_valid), 128'd0);
    chk("hold_abort_cnt", 128'(byte_cnt), 128'd0);
    chk("hold_abort_key_kept", blk_key, vecs[3].key);

    // Timeout: 7 idle cycles then a byte survives, 8 idle cycles drop the frame
    send_bytes(vecs[1].key, 5);
    repeat (TO - 1) cyc();
    chk("idle7_cnt", 128'(byte_cnt), 128'd5);
    chk("idle7_tout", 128'(timeout_err), 128'd0);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    cyc();
    in_valid = 1'b0;
    chk("byte_wins_cnt", 128'(byte_cnt), 128'd6);
    chk("byte_wins_tout", 128'(timeout_err), 128'd0);
    repeat (TO - 1) cyc();
    chk("idle7b_cnt", 128'(byte_cnt), 128'd6);
    cyc();
    chk("tout_pulse", 128'(timeout_err), 128'd1);
    chk("tout_cnt", 128'(byte_cnt), 128'd0);
    chk("tout_valid", 128'(blk_valid), 128'd0);
    cyc();
    chk("tout_one_cycle", 128'(timeout_err), 128'd0);
    sb_q.push_back(vecs[2]);
    send_frame(vecs[2].key, vecs[2].data);
    release_blk();
    pulse_abort();

    // Asynchronous reset at byte 25, asserted and released between edges
    send_bytes(vecs[0].key, 16);
    send_bytes(vecs[0].data, 8);
    in_valid = 1'b1;
    in_byte  = 8'h99;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(blk_valid), 128'd0);
    chk("arst_cnt", 128'(byte_cnt), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd0);
    chk("arst_key", blk_key, 128'd0);
    in_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rel_in_ready", 128'(in_ready), 128'd1);
    cyc();
    sb_q.push_back(vecs[1]);
    send_frame(vecs[1].key, vecs[1].data);
    release_blk();
    cyc();

    chk("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
